// File: rtl/bin_morph_3x3.sv
// bin_morph_3x3: 3x3 binary erosion/dilation over a vld/sop/eop framed pixel stream, two-clock latency.
module bin_morph_3x3 #(
   parameter int COL  = 640,
   parameter int ROW  = 480,
   parameter int MODE = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   input  logic din_vld,
   input  logic din_sop,
   input  logic din_eop,
   output logic dout,
   output logic dout_vld,
   output logic dout_sop,
   output logic dout_eop
);
   localparam int CW = $clog2(COL);
   localparam int RW = $clog2(ROW);
   logic [CW-1:0] col_cnt, cur_col;
   logic [RW-1:0] row_cnt, cur_row;
   logic [COL-1:0] lb0, lb1;
   logic [2:0] wa, wb, wc;
   logic m1, v1, s1, e1, win_val;
   always_comb begin
      cur_col = din_sop ? '0 : col_cnt;
      cur_row = din_sop ? '0 : row_cnt;
      win_val = MODE == 0 ? &{wa, wb, wc} : |{wa, wb, wc};
   end
   // Line buffers and window are never cleared; the mask hides whatever stale data they hold.
   always_ff @(posedge clk) begin
      if (din_vld) begin
         lb1[cur_col] <= lb0[cur_col];
         lb0[cur_col] <= din;
         wa <= wb;
         wb <= wc;
         wc <= {lb1[cur_col], lb0[cur_col], din};
         m1 <= (cur_row < RW'(2)) | (cur_col < CW'(2));
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         col_cnt  <= '0;
         row_cnt  <= '0;
         v1       <= 1'b0;
         s1       <= 1'b0;
         e1       <= 1'b0;
         dout     <= 1'b0;
         dout_vld <= 1'b0;
         dout_sop <= 1'b0;
         dout_eop <= 1'b0;
      end else begin
         v1       <= din_vld;
         s1       <= din_vld & din_sop;
         e1       <= din_vld & din_eop;
         dout_vld <= v1;
         dout_sop <= s1;
         dout_eop <= e1;
         if (v1) dout <= m1 ? 1'b0 : win_val;
         if (din_vld) begin
            col_cnt <= cur_col == CW'(COL - 1) ? '0 : cur_col + CW'(1);
            row_cnt <= din_eop || (cur_row == RW'(ROW - 1) && cur_col == CW'(COL - 1)) ? '0 :
                       cur_col == CW'(COL - 1) ? cur_row + RW'(1) : cur_row;
            if (din_eop) col_cnt <= '0;
         end
      end
   end
endmodule

// File: tb/tb_bin_morph_3x3.sv
// tb_bin_morph_3x3: erosion and dilation instances on a shared 8x4 stream, checked against an image-based scoreboard.
module tb_bin_morph_3x3;
   localparam int COL = 8;
   localparam int ROW = 4;
   localparam int N   = COL * ROW;
   typedef struct {
      logic ero, dil, sop, eop;
      int   cyc;
   } exp_t;
   logic clk = 0, rst = 1, din = 0, din_vld = 0, din_sop = 0, din_eop = 0;
   logic dout_e, vld_e, sop_e, eop_e, dout_d, vld_d, sop_d, eop_d;
   logic prev_e, prev_d;
   exp_t sb[$];
   exp_t mx;
   bit   img[ROW][COL];
   bit   in_rst = 1;
   int   cyc = 0, checks = 0, failures = 0, vld_cnt = 0;

   bin_morph_3x3 #(.COL(COL), .ROW(ROW), .MODE(0)) u_ero (
      .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_sop(din_sop), .din_eop(din_eop),
      .dout(dout_e), .dout_vld(vld_e), .dout_sop(sop_e), .dout_eop(eop_e));
   bin_morph_3x3 #(.COL(COL), .ROW(ROW), .MODE(1)) u_dil (
      .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_sop(din_sop), .din_eop(din_eop),
      .dout(dout_d), .dout_vld(vld_d), .dout_sop(sop_d), .dout_eop(eop_d));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic send(input bit d, input bit s, input bit e, input int r, input int c);
      exp_t x;
      bit ero, dil;
      img[r][c] = d;
      ero = (r >= 2 && c >= 2);
      dil = 0;
      if (ero)
         for (int i = r - 2; i <= r; i++)
            for (int j = c - 2; j <= c; j++) begin
               ero &= img[i][j];
               dil |= img[i][j];
            end
      x.ero = ero; x.dil = dil; x.sop = s; x.eop = e; x.cyc = cyc;
      sb.push_back(x);
      din = d; din_vld = 1; din_sop = s; din_eop = e;
      @(posedge clk); #1;
      din_vld = 0; din_sop = 0; din_eop = 0;
   endtask

   task automatic frame(input int kind, input int npix, input int gap_max);
      int r, c;
      bit d;
      for (int i = 0; i < npix; i++) begin
         r = i / COL;
         c = i % COL;
         d = kind == 1 ? (r == 1 && c == 3) : !(kind == 2 && r == 1 && c == 4);
         send(d, i == 0, i == N - 1, r, c);
         repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      end
   endtask

   task automatic drain();
      repeat (5) begin @(posedge clk); #1; end
   endtask

   always @(negedge clk) begin
      if (vld_e) begin
         check("vld_dil", vld_d, 1);
         if (sb.size() == 0) check("unexpected_vld", 1, 0);
         else begin
            mx = sb.pop_front();
            check("ero", dout_e, mx.ero);
            check("dil", dout_d, mx.dil);
            check("sop", sop_e, mx.sop);
            check("eop", eop_e, mx.eop);
            check("latency", cyc, mx.cyc + 2);
            vld_cnt++;
         end
      end else if (!in_rst) begin
         check("vld_dil_idle", vld_d, 0);
         check("hold_ero", dout_e, prev_e);
         check("hold_dil", dout_d, prev_d);
      end
      prev_e = dout_e;
      prev_d = dout_d;
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_dout", dout_e, 0);
      check("rst_vld", vld_e, 0);
      check("rst_sop", sop_e, 0);
      check("rst_eop", eop_e, 0);
      check("rst_dout_dil", dout_d, 0);
      rst = 0;
      @(posedge clk); #1;
      in_rst = 0;
      vld_cnt = 0;
      frame(0, N, 0);
      drain();
      check("s1_count", vld_cnt, N);
      frame(1, N, 0);
      drain();
      frame(2, N, 0);
      drain();
      vld_cnt = 0;
      frame(0, N, 3);
      drain();
      check("s4_count", vld_cnt, N);
      vld_cnt = 0;
      frame(0, 13, 0);
      frame(0, N, 0);
      drain();
      check("s5_count", vld_cnt, 13 + N);
      frame(0, 20, 0);
      in_rst = 1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      sb.delete();
      check("mid_rst_dout", dout_e, 0);
      check("mid_rst_vld", vld_e, 0);
      check("mid_rst_sop", sop_e, 0);
      check("mid_rst_eop", eop_e, 0);
      repeat (3) begin @(posedge clk); #1; end
      in_rst = 0;
      vld_cnt = 0;
      frame(0, N, 0);
      drain();
      check("s6_count", vld_cnt, N);
      check("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bin_morph_3x3.md
Name: bin_morph_3x3

Overview:
- 3x3 binary morphology stage that sits directly downstream of the gray-to-binary threshold stage in the edge-detection pipeline.
- Consumes the 1-bit pixel stream with vld/sop/eop framing and produces an eroded (or dilated) 1-bit stream in the same framing.
- Removes isolated noise (erode) or closes small gaps (dilate) before the edge/output stages.
- Uses two internal line buffers and a 3x3 window register array.

Parameters:
- COL, 640, pixels per line (>=3)
- ROW, 480, lines per frame (>=3)
- MODE, 0, 0 = erosion (AND of window), 1 = dilation (OR of window)

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- din  input  1  binary pixel
- din_vld  input  1  din valid, one pixel per cycle when high
- din_sop  input  1  first pixel of frame, qualified by din_vld
- din_eop  input  1  last pixel of frame, qualified by din_vld
- dout  output  1  morphology result
- dout_vld  output  1  dout valid
- dout_sop  output  1  first output pixel of frame
- dout_eop  output  1  last output pixel of frame

Behaviour:
- Clocking/reset: one clock (clk). Reset is synchronous and active-high (rst).
- While rst is high at a clk edge:
  - dout, dout_vld, dout_sop, dout_eop = 0; counters = 0; pipeline valids = 0.
  - Line buffer and window contents are not cleared; border masking makes stale data invisible.
- All state advances only on cycles with din_vld = 1. Cycles with din_vld = 0 hold all state; dout_vld deasserts accordingly. No backpressure.
- Counters col_cnt (0..COL-1) and row_cnt (0..ROW-1) give the position of the current input pixel.
  - din_vld & din_sop: current pixel is treated as (0,0), overriding the counters.
  - After pixel (r, COL-1): col_cnt -> 0, row_cnt -> r+1.
  - After din_eop, or after pixel (ROW-1, COL-1): both counters -> 0.
  - din_sop arriving mid-frame restarts the frame at (0,0); there is no error flag.
- Line buffers lb0 and lb1: COL x 1 bit each, indexed by col_cnt.
  - On a valid pixel at column c: read lb0[c] (row r-1) and lb1[c] (row r-2).
  - Same cycle: write lb1[c] <= lb0[c] and lb0[c] <= din (read-before-write).
- Window: 3 rows x 3 columns. On each valid pixel, shift left and load the new column {lb1[c], lb0[c], din}.
  - The window then holds rows r-2..r and columns c-2..c.
- Mask flag = (row_cnt < 2) | (col_cnt < 2), evaluated for the current pixel and registered with it. It marks an incomplete window.
- Pipeline (fixed latency of 2 clk from a sampled din_vld):
  - Stage 1 registers the window, mask, vld, sop and eop.
  - Stage 2: dout = mask ? 0 : (MODE == 0 ? AND of 9 bits : OR of 9 bits). dout_vld/sop/eop are the stage-1 flags delayed one more clock.
- Output frame size equals input frame size; one output per input pixel.
  - The result is spatially shifted by (+1, +1): output position (r,c) is centered on input (r-1, c-1).
  - Rows 0-1 and columns 0-1 of each output frame are forced to 0 in both modes.
- dout_sop/dout_eop are asserted exactly on the output pixels corresponding to the din_sop/din_eop input pixels.
- dout holds its last value while dout_vld = 0.
- Reset mid-frame: the partial frame is discarded. The next frame must begin with din_sop and is processed correctly, because masking covers stale buffer data.

Test Plan:
1. COL=8, ROW=4, MODE=0, all-ones frame, continuous vld -> 32 outputs.
   - Output 0 at rows 0-1 and at columns 0-1 of rows 2-3; 1 at (2..3, 2..7).
   - dout_sop on output 0, dout_eop on output 31; first dout_vld 2 clocks after first din_vld.
2. COL=8, ROW=4, MODE=1, all zeros except input (1,3) = 1 -> dout = 1 only at (2..3, 3..5); all other outputs 0.
3. COL=8, ROW=4, MODE=0, all ones except input (1,4) = 0 -> dout = 0 at (2..3, 4..6); dout = 1 at the remaining positions with row>=2, col>=2.
4. Repeat scenario 1 with random 0-3 cycle din_vld gaps.
   - The dout sequence sampled on dout_vld is identical to scenario 1; exactly 32 dout_vld pulses.
   - Each dout_vld occurs exactly 2 clocks after its din_vld.
5. Second din_sop injected at input pixel 13 of a frame, followed by a full 32-pixel all-ones frame -> counters restart.
   - The new frame's rows 0-1 and columns 0-1 output 0; the remainder equals scenario 1.
   - dout_sop is asserted on both sop pixels.
6. rst held high 1 clk mid-frame (pixel 20) -> all outputs 0 the following clock, no dout_vld until new input arrives.
   - A subsequent all-ones frame reproduces scenario 1 exactly.
